// File: rtl/ibex_dummy_instr_monitor_if.sv
// Handoff-observation bundle for the dummy instruction monitor.
// master: the IF/ID/CSR side that produces the observed signals and consumes the alert/count.
// slave : the monitor itself.
// Signals: dummy_instr_en_i, dummy_instr_mask_i, fetch_valid_i, insert_dummy_instr_i,
//          dummy_instr_data_i, id_in_ready_i, alert_clr_i (to monitor);
//          alert_o, alert_cause_o, dummy_cnt_o (from monitor).
interface ibex_dummy_instr_monitor_if #(
   parameter int unsigned CntW = 32
);
   logic            dummy_instr_en_i;
   logic [2:0]      dummy_instr_mask_i;
   logic            fetch_valid_i;
   logic            insert_dummy_instr_i;
   logic [31:0]     dummy_instr_data_i;
   logic            id_in_ready_i;
   logic            alert_clr_i;
   logic            alert_o;
   logic [1:0]      alert_cause_o;
   logic [CntW-1:0] dummy_cnt_o;

   modport master (
      output dummy_instr_en_i, dummy_instr_mask_i, fetch_valid_i, insert_dummy_instr_i,
             dummy_instr_data_i, id_in_ready_i, alert_clr_i,
      input  alert_o, alert_cause_o, dummy_cnt_o
   );

   modport slave (
      input  dummy_instr_en_i, dummy_instr_mask_i, fetch_valid_i, insert_dummy_instr_i,
             dummy_instr_data_i, id_in_ready_i, alert_clr_i,
      output alert_o, alert_cause_o, dummy_cnt_o
   );
endinterface

// File: rtl/ibex_dummy_instr_monitor.sv
// Monitor for dummy instructions injected at the IF->ID handoff.
// Checks dummy encodings, checks that dummies appear within the programmed gap
// (plus GapSlack), counts accepted dummies (saturating) and raises a sticky alert.
// Ports: clk_i, rst_i (synchronous, active-high), mon (slave modport of
//        ibex_dummy_instr_monitor_if carrying the handoff, CSR and alert signals).
// Optional feature: define IBEX_DUMMY_MON_DECODE_CHECK_EN to compile in the
// encoding check (cause bit1); otherwise cause bit1 is tied to 0.
module ibex_dummy_instr_monitor #(
   parameter int unsigned GapSlack = 2,
   parameter int unsigned CntW     = 32
) (
   input logic                        clk_i,
   input logic                        rst_i,
   ibex_dummy_instr_monitor_if.slave  mon
);

   localparam int unsigned GapW    = 6;
   localparam int unsigned GapIncW = GapW + 1;

   typedef enum logic [1:0] {
      StOff   = 2'd0,
      StSync  = 2'd1,
      StCheck = 2'd2
   } state_e;

   state_e            state_q;
   logic [GapW-1:0]   gap_q;
   logic [2:0]        mask_q;
   logic [CntW-1:0]   cnt_q;
   logic [1:0]        cause_q;
   logic              alert_q;

   logic              handoff_c;
   logic              dummy_hs_c;
   logic              real_hs_c;
   logic              mask_chg_c;
   logic [GapW-1:0]   gap_limit_c;
   logic [GapIncW-1:0] gap_inc_c;
   logic              gap_ovf_c;
   logic [1:0]        viol_c;
   logic [1:0]        cause_d_c;

   // Handoff classification; a dummy wins over a simultaneous real instruction
   assign handoff_c  = mon.id_in_ready_i & (mon.fetch_valid_i | mon.insert_dummy_instr_i);
   assign dummy_hs_c = handoff_c & mon.insert_dummy_instr_i;
   assign real_hs_c  = handoff_c & ~mon.insert_dummy_instr_i;
   assign mask_chg_c = mon.dummy_instr_mask_i != mask_q;

   // Gap limit and overrun detection (compare at one extra bit so the increment never wraps)
   assign gap_limit_c = GapW'({mon.dummy_instr_mask_i, 2'b11}) + GapW'(GapSlack);
   assign gap_inc_c   = {1'b0, gap_q} + GapIncW'(1);
   assign gap_ovf_c   = (state_q == StCheck) & real_hs_c & (gap_inc_c > {1'b0, gap_limit_c});

`ifdef IBEX_DUMMY_MON_DECODE_CHECK_EN
   logic [9:0] funct_c;
   logic       enc_legal_c;

   // Only harmless R-type ADD/AND/MUL/DIV writing x0 are legal dummies
   always_comb begin
      funct_c     = {mon.dummy_instr_data_i[31:25], mon.dummy_instr_data_i[14:12]};
      enc_legal_c = (mon.dummy_instr_data_i[6:0] == 7'b0110011) &&
                    (mon.dummy_instr_data_i[11:7] == 5'd0) &&
                    ((funct_c == 10'b0000000_000) || (funct_c == 10'b0000000_111) ||
                     (funct_c == 10'b0000001_000) || (funct_c == 10'b0000001_100));
   end

   assign viol_c[1] = dummy_hs_c & (~mon.dummy_instr_en_i | ~enc_legal_c);
`else
   logic unused_dummy_data;
   assign unused_dummy_data = ^mon.dummy_instr_data_i;
   assign viol_c[1]         = 1'b0;
`endif

   assign viol_c[0] = gap_ovf_c;

   // A clear in the same cycle as a new violation leaves only the new bits
   assign cause_d_c = mon.alert_clr_i ? viol_c : (cause_q | viol_c);

   // Monitor state, gap counter, dummy counter and sticky alert
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StOff;
         gap_q   <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         cause_q <= '0;
         alert_q <= 1'b0;
      end else begin
         mask_q  <= mon.dummy_instr_mask_i;
         cause_q <= cause_d_c;
         alert_q <= |cause_d_c;

         if (dummy_hs_c && (cnt_q != {CntW{1'b1}})) begin
            cnt_q <= cnt_q + CntW'(1);
         end

         if (!mon.dummy_instr_en_i) begin
            state_q <= StOff;
            gap_q   <= '0;
         end else if ((state_q != StOff) && mask_chg_c) begin
            state_q <= StSync;
            gap_q   <= '0;
         end else begin
            unique case (state_q)
               StOff: begin
                  state_q <= StSync;
                  gap_q   <= '0;
               end
               StSync: begin
                  if (dummy_hs_c) begin
                     state_q <= StCheck;
                     gap_q   <= '0;
                  end
               end
               StCheck: begin
                  if (dummy_hs_c || gap_ovf_c) begin
                     gap_q <= '0;
                  end else if (real_hs_c) begin
                     gap_q <= gap_inc_c[GapW-1:0];
                  end
               end
               default: begin
                  state_q <= StOff;
                  gap_q   <= '0;
               end
            endcase
         end
      end
   end

   assign mon.alert_o       = alert_q;
   assign mon.alert_cause_o = cause_q;
   assign mon.dummy_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ibex_dummy_instr_monitor.sv
// Randomized self-checking bench for ibex_dummy_instr_monitor against a behavioural model.
module tb_ibex_dummy_instr_monitor;

   localparam int unsigned CNT_W     = 8;
   localparam int unsigned GAP_SLACK = 2;
   localparam int          CNT_MAX   = (1 << CNT_W) - 1;

`ifdef IBEX_DUMMY_MON_DECODE_CHECK_EN
   localparam logic [1:0] ENC_BIT = 2'b10;
`else
   localparam logic [1:0] ENC_BIT = 2'b00;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   ibex_dummy_instr_monitor_if #(.CntW(CNT_W)) mon_if ();

   ibex_dummy_instr_monitor #(
      .GapSlack (GAP_SLACK),
      .CntW     (CNT_W)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .mon   (mon_if.slave)
   );

   // Reference model: phase 0 = monitoring off, 1 = waiting for first dummy, 2 = gap tracking
   int         m_phase;
   int         m_gap;
   int         m_cnt;
   logic [1:0] m_cause;
   logic [2:0] m_mask_prev;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit enc_ok(input logic [31:0] d);
      logic [6:0] f7;
      logic [2:0] f3;
      f7 = d[31:25];
      f3 = d[14:12];
      if (d[6:0] != 7'h33 || d[11:7] != 5'd0) return 1'b0;
      if (f7 == 7'd0) return (f3 == 3'd0) || (f3 == 3'd7);
      if (f7 == 7'd1) return (f3 == 3'd0) || (f3 == 3'd4);
      return 1'b0;
   endfunction

   task automatic model_step();
      bit         hs, dmy, rl, bad;
      int         lim;
      logic [1:0] viol;
      if (rst) begin
         m_phase = 0; m_gap = 0; m_cnt = 0; m_cause = 2'b00; m_mask_prev = 3'd0;
         return;
      end
      hs   = mon_if.id_in_ready_i && (mon_if.fetch_valid_i || mon_if.insert_dummy_instr_i);
      dmy  = hs && mon_if.insert_dummy_instr_i;
      rl   = hs && !mon_if.insert_dummy_instr_i;
      lim  = int'(mon_if.dummy_instr_mask_i) * 4 + 3 + int'(GAP_SLACK);
      viol = 2'b00;
      if (m_phase == 2) begin
         if (dmy) m_gap = 0;
         else if (rl) begin
            if (m_gap + 1 > lim) begin viol[0] = 1'b1; m_gap = 0; end
            else m_gap = m_gap + 1;
         end
      end
      if (dmy) begin
         bad = !mon_if.dummy_instr_en_i || !enc_ok(mon_if.dummy_instr_data_i);
         if (bad) viol = viol | ENC_BIT;
         if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
      m_cause = mon_if.alert_clr_i ? viol : (m_cause | viol);
      if (!mon_if.dummy_instr_en_i) m_phase = 0;
      else if (m_phase != 0 && mon_if.dummy_instr_mask_i != m_mask_prev) m_phase = 1;
      else if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1 && dmy) begin m_phase = 2; m_gap = 0; end
      if (m_phase != 2) m_gap = 0;
      m_mask_prev = mon_if.dummy_instr_mask_i;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("alert", 32'(mon_if.alert_o), 32'(|m_cause));
      check("cause", 32'(mon_if.alert_cause_o), 32'(m_cause));
      check("cnt", 32'(mon_if.dummy_cnt_o), 32'(m_cnt));
   endtask

   task automatic cyc(input bit en, input logic [2:0] mask, input bit fv, input bit ins,
                      input logic [31:0] data, input bit rdy, input bit clr);
      mon_if.dummy_instr_en_i     = en;
      mon_if.dummy_instr_mask_i   = mask;
      mon_if.fetch_valid_i        = fv;
      mon_if.insert_dummy_instr_i = ins;
      mon_if.dummy_instr_data_i   = data;
      mon_if.id_in_ready_i        = rdy;
      mon_if.alert_clr_i          = clr;
      tick();
   endtask

   function automatic logic [31:0] rand_data();
      logic [31:0] rs;
      rs = {7'd0, 10'($urandom), 15'd0};
      case ($urandom_range(0, 6))
         0: return 32'h0000_0033 | rs;
         1: return 32'h0000_7033 | rs;
         2: return 32'h0200_0033 | rs;
         3: return 32'h0200_4033 | rs;
         4: return 32'h0000_00B3;
         5: return 32'h4000_0033;
         default: return $urandom;
      endcase
   endfunction

   localparam logic [31:0] ADD0 = 32'h0000_0033;

   initial begin
      bit         en;
      logic [2:0] mask;
      rst = 1'b1;
      // Reset then idle
      for (int i = 0; i < 3; i++) cyc(0, 3'd0, 0, 0, 32'd0, 0, 0);
      check("rst_alert", 32'(mon_if.alert_o), 32'd0);
      check("rst_cnt", 32'(mon_if.dummy_cnt_o), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) cyc(0, 3'd0, 0, 0, 32'd0, 1, 0);
      check("idle_alert", 32'(mon_if.alert_o), 32'd0);

      // Legal stream: three real handoffs then one ADD x0 dummy
      for (int i = 0; i < 200; i++) begin
         if ((i % 4) == 3) cyc(1, 3'd0, 0, 1, ADD0, 1, 0);
         else              cyc(1, 3'd0, 1, 0, 32'd0, 1, 0);
      end
      check("legal_alert", 32'(mon_if.alert_o), 32'd0);
      check("legal_cnt", 32'(mon_if.dummy_cnt_o), 32'd50);

      // Gap overrun at limit 5
      for (int i = 0; i < 5; i++) cyc(1, 3'd0, 1, 0, 32'd0, 1, 0);
      check("gap_at_limit", 32'(mon_if.alert_cause_o), 32'd0);
      cyc(1, 3'd0, 1, 0, 32'd0, 1, 0);
      check("gap_overrun", 32'(mon_if.alert_cause_o), 32'd1);
      cyc(1, 3'd0, 0, 0, 32'd0, 1, 1);
      check("gap_clear", 32'(mon_if.alert_o), 32'd0);

      // Illegal encodings
      cyc(1, 3'd0, 0, 1, 32'h0000_00B3, 1, 0);
      check("enc_rd1", 32'(mon_if.alert_cause_o), 32'(ENC_BIT));
      cyc(1, 3'd0, 0, 0, 32'd0, 1, 1);
      cyc(1, 3'd0, 1, 1, 32'h4000_0033, 1, 0);
      check("enc_sub", 32'(mon_if.alert_cause_o), 32'(ENC_BIT));
      cyc(1, 3'd0, 0, 0, 32'd0, 1, 1);

      // Mask change mid-gap resynchronises
      cyc(1, 3'd0, 0, 1, ADD0, 1, 0);
      cyc(1, 3'd0, 1, 0, 32'd0, 1, 0);
      cyc(1, 3'd0, 1, 0, 32'd0, 1, 0);
      cyc(1, 3'd1, 0, 0, 32'd0, 1, 0);
      for (int i = 0; i < 40; i++) cyc(1, 3'd1, 1, 0, 32'd0, 1, 0);
      check("resync_alert", 32'(mon_if.alert_o), 32'd0);
      cyc(1, 3'd1, 0, 1, ADD0, 1, 0);
      for (int i = 0; i < 9; i++) cyc(1, 3'd1, 1, 0, 32'd0, 1, 0);
      check("limit9_ok", 32'(mon_if.alert_o), 32'd0);
      cyc(1, 3'd1, 1, 0, 32'd0, 1, 0);
      check("limit9_over", 32'(mon_if.alert_cause_o), 32'd1);
      cyc(1, 3'd1, 0, 0, 32'd0, 1, 1);

      // Disable: no gap checks, dummies while disabled are illegal
      cyc(0, 3'd1, 0, 0, 32'd0, 1, 0);
      for (int i = 0; i < 20; i++) cyc(0, 3'd1, 1, 0, 32'd0, 1, 0);
      check("off_alert", 32'(mon_if.alert_o), 32'd0);
      cyc(0, 3'd1, 0, 1, ADD0, 1, 0);
      check("off_dummy", 32'(mon_if.alert_cause_o), 32'(ENC_BIT));
      cyc(0, 3'd1, 0, 0, 32'd0, 1, 1);

      // Clear together with a new gap violation
      cyc(1, 3'd0, 0, 0, 32'd0, 1, 0);
      cyc(1, 3'd0, 0, 1, ADD0, 1, 0);
      cyc(1, 3'd0, 0, 1, 32'h0000_00B3, 1, 0);
      for (int i = 0; i < 5; i++) cyc(1, 3'd0, 1, 0, 32'd0, 1, 0);
      cyc(1, 3'd0, 1, 0, 32'd0, 1, 1);
      check("clr_and_new", 32'(mon_if.alert_cause_o), 32'd1);

      // Randomized traffic
      en = 1'b1;
      mask = 3'd0;
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 99) < 2) en = ~en;
         if ($urandom_range(0, 99) < 3) mask = 3'($urandom);
         cyc(en, mask, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2), rand_data(),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      end

      // Mid-stream reset
      rst = 1'b1;
      cyc(1, 3'd2, 1, 1, 32'h0000_00B3, 1, 0);
      check("mid_rst_cause", 32'(mon_if.alert_cause_o), 32'd0);
      check("mid_rst_cnt", 32'(mon_if.dummy_cnt_o), 32'd0);
      rst = 1'b0;

      // Saturation
      for (int i = 0; i < 300 && m_cnt < CNT_MAX - 1; i++) cyc(1, 3'd2, 0, 1, ADD0, 1, 0);
      check("sat_pre", 32'(mon_if.dummy_cnt_o), 32'(CNT_MAX - 1));
      for (int i = 0; i < 3; i++) cyc(1, 3'd2, 1, 1, ADD0, 1, 0);
      check("sat_hold", 32'(mon_if.dummy_cnt_o), 32'(CNT_MAX));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
